tinker_mem_arbiter: RTL and testbench
=====================================

// Module: tinker_mem_arbiter
// PURPOSE
//  Shares the single tinker_core byte memory port between the instruction-fetch requester (IF) and the
//  data requester (D: ld/st/call push/ret pop) with valid/ready handshakes. One access in flight at a time.
//  Sequences each access through a latency-parameterised memory port and returns a one-cycle response pulse.
//  Guarantees fetch forward progress via a starvation counter; range-checks addresses before issue.
// PARAMETERS
//  LATENCY    2       cycles from mem_en to mem_rdata valid (>=1)
//  MEM_BYTES  524288  memory size in bytes; range-check limit
//  STARVE_MAX 4       consecutive denied IF cycles before IF is forced to win (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset (0 = in reset)
//  if_req_valid  in   1   IF request valid
//  if_req_ready  out  1   IF request accepted when valid&ready
//  if_req_addr   in   64  IF byte address (4-byte read)
//  if_resp_valid out  1   one-cycle pulse: IF response
//  if_resp_data  out  32  instruction word, little-endian
//  if_resp_err   out  1   IF address fault (valid with if_resp_valid)
//  d_req_valid   in   1   D request valid
//  d_req_ready   out  1   D request accepted when valid&ready
//  d_req_addr    in   64  D byte address (8-byte access)
//  d_req_we      in   1   1 = store, 0 = load
//  d_req_wdata   in   64  store data
//  d_resp_valid  out  1   one-cycle pulse: D response (load data or store ack)
//  d_resp_data   out  64  load data; 0 for stores and faults
//  d_resp_err    out  1   D address fault
//  mem_en        out  1   memory access strobe, one cycle per access
//  mem_we        out  1   memory write enable (qualified by mem_en)
//  mem_addr      out  64  memory byte address
//  mem_wdata     out  64  memory write data
//  mem_rdata     in   64  memory read data, valid LATENCY cycles after mem_en
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, starve_cnt=0, every output 0, in-flight access discarded (no resp).
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; fault path IDLE -> RESP directly.
//  IDLE: ready asserted combinationally to the granted requester only; other ready=0. No ready outside IDLE.
//   Grant: only one valid -> that one; both valid -> D, unless starve_cnt==STARVE_MAX -> IF.
//   On accept latch requester, addr, we, wdata. Fault check on latched request:
//    IF: addr[1:0]!=0 or addr+4>MEM_BYTES; D: addr+8>MEM_BYTES (no alignment rule; 65-bit compare, no wrap).
//   Fault -> RESP, no mem_en. Otherwise -> ISSUE.
//  starve_cnt: +1 each IDLE cycle with if_req_valid=1 and IF not granted, saturates at STARVE_MAX;
//   cleared on IF accept; held in other states.
//  ISSUE (1 cycle): mem_en=1, mem_we=latched we (IF always 0), mem_addr/mem_wdata from latch.
//   mem_addr/mem_wdata/mem_we are 0 whenever mem_en=0.
//  WAIT: cycle counter from 1 to LATENCY; in the cycle the count reaches LATENCY, capture mem_rdata, go RESP.
//  RESP (1 cycle): pulse resp_valid of latched requester; IF data=captured[31:0], D data=captured
//   (0 for store or fault); err=fault flag. Other requester's resp outputs stay 0. -> IDLE.
//  Latency: accept at cycle t -> mem_en at t+1 -> resp_valid at t+2+LATENCY (fault: resp at t+1).
//  Next accept no earlier than the cycle after RESP; max one access per LATENCY+3 cycles.
//  Request inputs are ignored outside IDLE; requesters hold valid/addr until accepted.
//  No response back-pressure: requesters must sample resp in the pulse cycle.
// TESTING (LATENCY=2, STARVE_MAX=4)
//  D load 0x100 alone, mem holds 0x1122334455667788 -> d_req_ready same cycle; mem_en 1 cycle later;
//   d_resp_valid=1, data=0x1122334455667788 at accept+4; if_resp_valid stays 0.
//  IF and D valid together in IDLE, starve_cnt=0 -> D granted, if_req_ready=0; IF served on next IDLE.
//  IF held valid with D re-requesting back-to-back -> IF denied 4 IDLE cycles, 5th IDLE grants IF,
//   starve_cnt returns to 0.
//  IF addr 0x2002 -> if_resp_valid=1, if_resp_err=1, data 0 at accept+1, mem_en never asserted;
//   D addr 0x7FFF9 -> d_resp_err=1.
//  D store 0x2000 data 0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; d_resp_valid with data 0, err 0.
//  reset driven 0 in WAIT -> outputs 0 immediately, no resp pulse after release; next request served normally.

Source files
------------

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: shares the single byte memory port between the
// instruction-fetch and data requesters, one access in flight at a time.
module tinker_mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MEM_BYTES  = 524288,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [63:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_data,
  output logic        d_resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [64:0] LIMIT = 65'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic [CW-1:0] cnt_q;
  logic          is_if_q;
  logic          we_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;

  logic          if_rv_q;
  logic          if_re_q;
  logic [31:0]   if_rd_q;
  logic          d_rv_q;
  logic          d_re_q;
  logic [63:0]   d_rd_q;

  logic idle;
  logic starved;
  logic grant_if;
  logic grant_d;
  logic if_acc;
  logic d_acc;
  logic acc;
  logic if_fault;
  logic d_fault;
  logic fault;

  // Bounds use a 65-bit sum so addresses near 2^64 cannot wrap into range.
  always_comb begin
    idle     = reset && (state_q == IDLE);
    starved  = (starve_q == SW'(STARVE_MAX));
    grant_if = if_req_valid && (!d_req_valid || starved);
    grant_d  = d_req_valid && !grant_if;
    if_acc   = idle && grant_if;
    d_acc    = idle && grant_d;
    acc      = if_acc || d_acc;
    if_fault = (if_req_addr[1:0] != 2'b00)
            || (({1'b0, if_req_addr} + 65'd4) > LIMIT);
    d_fault  = ({1'b0, d_req_addr} + 65'd8) > LIMIT;
    fault    = if_acc ? if_fault : d_fault;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      cnt_q    <= '0;
      is_if_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rv_q  <= 1'b0;
      if_re_q  <= 1'b0;
      if_rd_q  <= '0;
      d_rv_q   <= 1'b0;
      d_re_q   <= 1'b0;
      d_rd_q   <= '0;
    end else begin
      if_rv_q <= 1'b0;
      if_re_q <= 1'b0;
      if_rd_q <= '0;
      d_rv_q  <= 1'b0;
      d_re_q  <= 1'b0;
      d_rd_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (if_acc) begin
            starve_q <= '0;
          end else if (if_req_valid && !starved) begin
            starve_q <= starve_q + 1'b1;
          end
          if (acc) begin
            is_if_q <= if_acc;
            addr_q  <= if_acc ? if_req_addr : d_req_addr;
            we_q    <= d_acc && d_req_we;
            wdata_q <= d_acc ? d_req_wdata : '0;
            cnt_q   <= '0;
            if (fault) begin
              state_q <= RESP;
              if_rv_q <= if_acc;
              if_re_q <= if_acc;
              d_rv_q  <= d_acc;
              d_re_q  <= d_acc;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= CW'(1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CW'(LATENCY)) begin
            state_q <= RESP;
            if_rv_q <= is_if_q;
            d_rv_q  <= !is_if_q;
            if (is_if_q) begin
              if_rd_q <= mem_rdata[31:0];
            end else if (!we_q) begin
              d_rd_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_req_ready  = if_acc;
  assign d_req_ready   = d_acc;

  assign if_resp_valid = if_rv_q;
  assign if_resp_err   = if_re_q;
  assign if_resp_data  = if_rd_q;
  assign d_resp_valid  = d_rv_q;
  assign d_resp_err    = d_re_q;
  assign d_resp_data   = d_rd_q;

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: randomized and directed bench for the memory
// arbiter, with a byte-array memory model and a reference model.
module tb_tinker_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;
  localparam longint unsigned MB = 524288;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_req_addr = '0;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [63:0] d_req_addr = '0;
  logic        d_req_we = 1'b0;
  logic [63:0] d_req_wdata = '0;
  logic        d_resp_valid;
  logic [63:0] d_resp_data;
  logic        d_resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  tinker_mem_arbiter #(
    .LATENCY(LAT),
    .MEM_BYTES(524288),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid),
    .if_resp_data(if_resp_data),
    .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr),
    .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data),
    .d_resp_err(d_resp_err),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model (mem) and the reference model's own view (rmem)
  logic [7:0]  mem  [longint unsigned];
  logic [7:0]  rmem [longint unsigned];
  logic [63:0] pipe [LAT];

  assign mem_rdata = pipe[LAT-1];

  function automatic logic [63:0] rd(input bit r, input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      longint unsigned k;
      k = a + 64'(i);
      if (r) begin
        if (rmem.exists(k)) v[8*i +: 8] = rmem[k];
      end else begin
        if (mem.exists(k)) v[8*i +: 8] = mem[k];
      end
    end
    return v;
  endfunction

  function automatic void wr(input bit r, input logic [63:0] a,
                             input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      longint unsigned k;
      k = a + 64'(i);
      if (r) rmem[k] = v[8*i +: 8];
      else   mem[k]  = v[8*i +: 8];
    end
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mem_en ? rd(1'b0, mem_addr) : 64'hA5A5_5A5A_DEAD_0BAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) wr(1'b0, mem_addr, mem_wdata);
  end

  typedef struct {
    int          c;
    logic [63:0] d;
    logic        e;
  } rsp_t;

  typedef struct {
    int          c;
    logic        we;
    logic [63:0] a;
    logic [63:0] w;
  } mev_t;

  rsp_t ifq[$];
  rsp_t dq[$];
  int   ifa[$];
  int   da[$];
  mev_t mq[$];

  always @(negedge clk) begin
    if (if_resp_valid) ifq.push_back('{cyc, {32'h0, if_resp_data}, if_resp_err});
    if (d_resp_valid) dq.push_back('{cyc, d_resp_data, d_resp_err});
    if (if_req_valid && if_req_ready) ifa.push_back(cyc);
    if (d_req_valid && d_req_ready) da.push_back(cyc);
    if (mem_en) mq.push_back('{cyc, mem_we, mem_addr, mem_wdata});
    if (!mem_en) begin
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        n_fail++;
        $display("FAIL mem_idle_zero: we=%b addr=%h wdata=%h, want all 0",
                 mem_we, mem_addr, mem_wdata);
      end
    end
    if (!if_resp_valid) begin
      n_checks++;
      if (if_resp_data !== '0 || if_resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL if_resp_idle: data=%h err=%b, want 0",
                 if_resp_data, if_resp_err);
      end
    end
    if (!d_resp_valid) begin
      n_checks++;
      if (d_resp_data !== '0 || d_resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL d_resp_idle: data=%h err=%b, want 0",
                 d_resp_data, d_resp_err);
      end
    end
  end

  function automatic bit if_bad(input logic [63:0] a);
    return (a % 4 != 0) || (a > MB - 4);
  endfunction

  function automatic bit d_bad(input logic [63:0] a);
    return a > MB - 8;
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] r;
    case ($urandom_range(3, 0))
      0: r = 64'($urandom_range(255, 0)) << 2;
      1: r = 64'($urandom_range(1023, 0));
      2: r = 64'(MB - 16 + 64'($urandom_range(15, 0)));
      default: r = {32'($urandom), 32'($urandom)};
    endcase
    return r;
  endfunction

  task automatic clr();
    ifq.delete();
    dq.delete();
    ifa.delete();
    da.delete();
    mq.delete();
  endtask

  // Drives one request per active requester and holds it until accepted
  task automatic xfer(input bit iv, input logic [63:0] ia,
                      input bit dv, input logic [63:0] dad,
                      input bit dwe, input logic [63:0] dwd,
                      output int t0);
    bit ai;
    bit ad;
    int lim;
    clr();
    if_req_addr  = ia;
    d_req_addr   = dad;
    d_req_we     = dwe;
    d_req_wdata  = dwd;
    if_req_valid = iv;
    d_req_valid  = dv;
    t0  = cyc;
    lim = cyc + 60;
    while ((if_req_valid || d_req_valid ||
            (ifq.size() + dq.size() < int'(iv) + int'(dv))) && cyc < lim) begin
      @(negedge clk);
      ai = if_req_valid && if_req_ready;
      ad = d_req_valid && d_req_ready;
      @(posedge clk);
      #1;
      if (ai) if_req_valid = 1'b0;
      if (ad) d_req_valid = 1'b0;
    end
    n_checks++;
    if (cyc >= lim) begin
      n_fail++;
      $display("FAIL xfer_timeout: %0d cycles without completion, want < 60",
               cyc - t0);
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    if_req_addr  = 64'h100;
    d_req_addr   = 64'h100;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_req_ready, d_req_ready, if_resp_valid, d_resp_valid,
         mem_en, mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b%b rv=%b%b en=%b we=%b, want 0",
               if_req_ready, d_req_ready, if_resp_valid, d_resp_valid,
               mem_en, mem_we);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h wdata=%h, want 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (if_resp_data !== '0 || d_resp_data !== '0 ||
        if_resp_err !== 1'b0 || d_resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: ifd=%h dd=%h errs=%b%b, want 0",
               if_resp_data, d_resp_data, if_resp_err, d_resp_err);
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_d_load();
    int t0;
    logic [63:0] exp;
    wr(1'b0, 64'h100, 64'h1122334455667788);
    wr(1'b1, 64'h100, 64'h1122334455667788);
    exp = rd(1'b1, 64'h100);
    xfer(1'b0, '0, 1'b1, 64'h100, 1'b0, '0, t0);
    n_checks++;
    if (da.size() != 1 || da[0] != t0) begin
      n_fail++;
      $display("FAIL d_load_accept: n=%0d cyc=%0d, want 1 at %0d",
               da.size(), da[0], t0);
    end
    n_checks++;
    if (mq.size() != 1 || mq[0].c != t0 + 1 || mq[0].we !== 1'b0 ||
        mq[0].a !== 64'h100) begin
      n_fail++;
      $display("FAIL d_load_mem: n=%0d cyc=%0d we=%b a=%h, want 1 at %0d we=0 a=100",
               mq.size(), mq[0].c, mq[0].we, mq[0].a, t0 + 1);
    end
    n_checks++;
    if (dq.size() != 1 || dq[0].c != t0 + 2 + LAT || dq[0].d !== exp ||
        dq[0].e !== 1'b0) begin
      n_fail++;
      $display("FAIL d_load_resp: n=%0d cyc=%0d d=%h e=%b, want cyc %0d d=%h e=0",
               dq.size(), dq[0].c, dq[0].d, dq[0].e, t0 + 2 + LAT, exp);
    end
    n_checks++;
    if (ifq.size() != 0) begin
      n_fail++;
      $display("FAIL d_load_no_if: if responses=%0d, want 0", ifq.size());
    end
  endtask

  task automatic test_arb_both();
    int t0;
    logic [63:0] w;
    logic [63:0] ed;
    wr(1'b0, 64'h200, 64'hCAFEF00D_12345678);
    wr(1'b1, 64'h200, 64'hCAFEF00D_12345678);
    w  = rd(1'b1, 64'h200);
    ed = rd(1'b1, 64'h108);
    xfer(1'b1, 64'h200, 1'b1, 64'h108, 1'b0, '0, t0);
    n_checks++;
    if (da.size() != 1 || da[0] != t0) begin
      n_fail++;
      $display("FAIL both_d_first: d accept cyc=%0d, want %0d", da[0], t0);
    end
    n_checks++;
    if (ifa.size() != 1 || dq.size() != 1 || ifa[0] != dq[0].c + 1) begin
      n_fail++;
      $display("FAIL both_if_next: if accept cyc=%0d, want %0d",
               ifa[0], dq[0].c + 1);
    end
    n_checks++;
    if (ifq.size() != 1 || ifq[0].d !== {32'h0, w[31:0]} ||
        ifq[0].c != ifa[0] + 2 + LAT || dq[0].d !== ed) begin
      n_fail++;
      $display("FAIL both_data: if=%h@%0d d=%h, want if=%h@%0d d=%h",
               ifq[0].d, ifq[0].c, dq[0].d, w[31:0], ifa[0] + 2 + LAT, ed);
    end
  endtask

  task automatic test_starve();
    bit seq[$];
    bit exp;
    int denied;
    int i;
    int j;
    int lim;
    logic [63:0] w;
    clr();
    wr(1'b0, 64'h300, 64'h0BAD_F00D_8765_4321);
    wr(1'b1, 64'h300, 64'h0BAD_F00D_8765_4321);
    w = rd(1'b1, 64'h300);
    if_req_addr  = 64'h300;
    d_req_addr   = 64'h110;
    d_req_we     = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    lim = cyc + 400;
    while (ifa.size() + da.size() < 10 && cyc < lim) @(posedge clk);
    #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    i = 0;
    j = 0;
    while (i < ifa.size() || j < da.size()) begin
      if (j >= da.size() || (i < ifa.size() && ifa[i] < da[j])) begin
        seq.push_back(1'b1);
        i++;
      end else begin
        seq.push_back(1'b0);
        j++;
      end
    end
    n_checks++;
    if (seq.size() != 10) begin
      n_fail++;
      $display("FAIL starve_count: accepts=%0d, want 10", seq.size());
    end
    denied = 0;
    for (int k = 0; k < seq.size(); k++) begin
      exp = (denied == SMAX);
      denied = exp ? 0 : denied + 1;
      n_checks++;
      if (seq[k] !== exp) begin
        n_fail++;
        $display("FAIL starve_grant[%0d]: got %s, want %s", k,
                 seq[k] ? "IF" : "D", exp ? "IF" : "D");
      end
    end
    n_checks++;
    if (ifq.size() != 2 || ifq[0].d !== {32'h0, w[31:0]} ||
        ifq[1].d !== {32'h0, w[31:0]}) begin
      n_fail++;
      $display("FAIL starve_if_data: n=%0d d=%h, want 2 x %h",
               ifq.size(), ifq[0].d, w[31:0]);
    end
  endtask

  typedef struct {
    bit          isif;
    logic [63:0] a;
    bit          err;
  } fc_t;

  task automatic test_fault();
    fc_t tab [9];
    int t0;
    rsp_t r;
    int acc;
    logic [63:0] v;
    logic [63:0] exp;
    tab[0] = '{1'b1, 64'h2002, 1'b1};
    tab[1] = '{1'b0, 64'h7FFF9, 1'b1};
    tab[2] = '{1'b0, 64'h7FFF8, 1'b0};
    tab[3] = '{1'b1, 64'h7FFFC, 1'b0};
    tab[4] = '{1'b1, 64'h7FFFD, 1'b1};
    tab[5] = '{1'b1, 64'h80000, 1'b1};
    tab[6] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    tab[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1};
    tab[8] = '{1'b0, 64'h3, 1'b0};
    wr(1'b0, 64'h7FFF8, 64'h0102030405060708);
    wr(1'b1, 64'h7FFF8, 64'h0102030405060708);
    for (int k = 0; k < 9; k++) begin
      xfer(tab[k].isif, tab[k].a, !tab[k].isif, tab[k].a, 1'b0, '0, t0);
      r   = tab[k].isif ? ifq[0] : dq[0];
      acc = tab[k].isif ? ifa[0] : da[0];
      v   = rd(1'b1, tab[k].a);
      exp = tab[k].err ? 64'h0 : (tab[k].isif ? {32'h0, v[31:0]} : v);
      n_checks++;
      if (ifq.size() + dq.size() != 1 || r.e !== tab[k].err || r.d !== exp) begin
        n_fail++;
        $display("FAIL fault[%0d] a=%h: e=%b d=%h, want e=%b d=%h",
                 k, tab[k].a, r.e, r.d, tab[k].err, exp);
      end
      n_checks++;
      if (r.c - acc != (tab[k].err ? 1 : 2 + LAT) ||
          mq.size() != (tab[k].err ? 0 : 1)) begin
        n_fail++;
        $display("FAIL fault_timing[%0d]: lat=%0d mem_en=%0d, want lat=%0d mem_en=%0d",
                 k, r.c - acc, mq.size(), tab[k].err ? 1 : 2 + LAT,
                 tab[k].err ? 0 : 1);
      end
    end
  endtask

  task automatic test_store();
    int t0;
    logic [63:0] exp;
    xfer(1'b0, '0, 1'b1, 64'h2000, 1'b1, 64'hDEADBEEF, t0);
    wr(1'b1, 64'h2000, 64'hDEADBEEF);
    n_checks++;
    if (mq.size() != 1 || mq[0].c != t0 + 1 || mq[0].we !== 1'b1 ||
        mq[0].a !== 64'h2000 || mq[0].w !== 64'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_mem: n=%0d cyc=%0d we=%b a=%h w=%h, want we=1 a=2000 w=deadbeef",
               mq.size(), mq[0].c, mq[0].we, mq[0].a, mq[0].w);
    end
    n_checks++;
    if (dq.size() != 1 || dq[0].d !== '0 || dq[0].e !== 1'b0 ||
        dq[0].c != t0 + 2 + LAT) begin
      n_fail++;
      $display("FAIL store_ack: d=%h e=%b cyc=%0d, want d=0 e=0 cyc=%0d",
               dq[0].d, dq[0].e, dq[0].c, t0 + 2 + LAT);
    end
    exp = rd(1'b1, 64'h2000);
    xfer(1'b0, '0, 1'b1, 64'h2000, 1'b0, '0, t0);
    n_checks++;
    if (dq.size() != 1 || dq[0].d !== exp) begin
      n_fail++;
      $display("FAIL store_readback: d=%h, want %h", dq[0].d, exp);
    end
  endtask

  task automatic test_reset_wait();
    int t0;
    logic [63:0] exp;
    clr();
    d_req_addr  = 64'h100;
    d_req_we    = 1'b0;
    d_req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    d_req_valid  = 1'b1;
    if_req_valid = 1'b1;
    #1;
    n_checks++;
    if ({if_req_ready, d_req_ready, if_resp_valid, d_resp_valid,
         if_resp_err, d_resp_err, mem_en, mem_we} !== 8'b0) begin
      n_fail++;
      $display("FAIL rst_wait_ctrl: rdy=%b%b rv=%b%b en=%b, want 0",
               if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_en);
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 ||
        if_resp_data !== '0 || d_resp_data !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_data: addr=%h wd=%h ifd=%h dd=%h, want 0",
               mem_addr, mem_wdata, if_resp_data, d_resp_data);
    end
    repeat (2) @(posedge clk);
    #1;
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    n_checks++;
    if (dq.size() != 0 || ifq.size() != 0) begin
      n_fail++;
      $display("FAIL rst_wait_no_resp: d=%0d if=%0d responses, want 0",
               dq.size(), ifq.size());
    end
    exp = rd(1'b1, 64'h100);
    xfer(1'b0, '0, 1'b1, 64'h100, 1'b0, '0, t0);
    n_checks++;
    if (dq.size() != 1 || dq[0].d !== exp || dq[0].c != t0 + 2 + LAT) begin
      n_fail++;
      $display("FAIL rst_wait_after: d=%h cyc=%0d, want %h at %0d",
               dq[0].d, dq[0].c, exp, t0 + 2 + LAT);
    end
  endtask

  task automatic test_random();
    int mstarve;
    mstarve = 0;
    for (int n = 0; n < 30; n++) begin
      bit iv;
      bit dv;
      bit dwe;
      bit if_first;
      bit eife;
      bit de;
      logic [63:0] ia;
      logic [63:0] dad;
      logic [63:0] dwd;
      logic [63:0] eif;
      logic [63:0] ed;
      logic [63:0] w;
      int sel;
      int t0;
      int first;
      int nok;
      sel = $urandom_range(2, 0);
      iv  = (sel != 1);
      dv  = (sel != 0);
      ia  = pick_addr();
      dad = pick_addr();
      dwe = 1'($urandom_range(1, 0));
      dwd = {32'($urandom), 32'($urandom)};
      if_first = iv && (!dv || mstarve == SMAX);
      if (iv && !if_first && mstarve < SMAX) mstarve++;
      if (iv) mstarve = 0;
      eife = 1'b0;
      eif  = '0;
      de   = 1'b0;
      ed   = '0;
      if (iv && if_first) begin
        eife = if_bad(ia);
        w    = rd(1'b1, ia);
        eif  = eife ? 64'h0 : {32'h0, w[31:0]};
      end
      if (dv) begin
        de = d_bad(dad);
        ed = (de || dwe) ? 64'h0 : rd(1'b1, dad);
        if (!de && dwe) wr(1'b1, dad, dwd);
      end
      if (iv && !if_first) begin
        eife = if_bad(ia);
        w    = rd(1'b1, ia);
        eif  = eife ? 64'h0 : {32'h0, w[31:0]};
      end
      xfer(iv, ia, dv, dad, dwe, dwd, t0);
      n_checks++;
      if (ifq.size() != int'(iv) || dq.size() != int'(dv) ||
          ifa.size() != int'(iv) || da.size() != int'(dv)) begin
        n_fail++;
        $display("FAIL rnd[%0d]_counts: if=%0d/%0d d=%0d/%0d, want %0d %0d",
                 n, ifa.size(), ifq.size(), da.size(), dq.size(), iv, dv);
      end
      if (iv && ifq.size() == 1 && ifa.size() == 1) begin
        n_checks++;
        if (ifq[0].d !== eif || ifq[0].e !== eife) begin
          n_fail++;
          $display("FAIL rnd[%0d]_if a=%h: d=%h e=%b, want d=%h e=%b",
                   n, ia, ifq[0].d, ifq[0].e, eif, eife);
        end
        n_checks++;
        if (ifq[0].c - ifa[0] != (eife ? 1 : 2 + LAT)) begin
          n_fail++;
          $display("FAIL rnd[%0d]_if_lat: %0d, want %0d",
                   n, ifq[0].c - ifa[0], eife ? 1 : 2 + LAT);
        end
      end
      if (dv && dq.size() == 1 && da.size() == 1) begin
        n_checks++;
        if (dq[0].d !== ed || dq[0].e !== de) begin
          n_fail++;
          $display("FAIL rnd[%0d]_d a=%h we=%b: d=%h e=%b, want d=%h e=%b",
                   n, dad, dwe, dq[0].d, dq[0].e, ed, de);
        end
        n_checks++;
        if (dq[0].c - da[0] != (de ? 1 : 2 + LAT)) begin
          n_fail++;
          $display("FAIL rnd[%0d]_d_lat: %0d, want %0d",
                   n, dq[0].c - da[0], de ? 1 : 2 + LAT);
        end
      end
      if (iv && dv && ifa.size() == 1 && da.size() == 1) begin
        n_checks++;
        if ((ifa[0] < da[0]) != if_first) begin
          n_fail++;
          $display("FAIL rnd[%0d]_order: if_first=%b, want %b",
                   n, ifa[0] < da[0], if_first);
        end
      end
      first = (ifa.size() > 0) ? ifa[0] : 1 << 30;
      if (da.size() > 0 && da[0] < first) first = da[0];
      n_checks++;
      if (first != t0) begin
        n_fail++;
        $display("FAIL rnd[%0d]_first_accept: cyc=%0d, want %0d", n, first, t0);
      end
      nok = (iv && !eife ? 1 : 0) + (dv && !de ? 1 : 0);
      n_checks++;
      if (mq.size() != nok) begin
        n_fail++;
        $display("FAIL rnd[%0d]_mem_en: %0d strobes, want %0d", n, mq.size(), nok);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_d_load();
    test_arb_both();
    test_starve();
    test_fault();
    test_store();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
